// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR stages and the period monitor.
package lfsr_pkg;

   // Default data width of an LFSR stream
   localparam int unsigned LfsrWidth = 8;

   // Period monitor state encoding
   typedef logic [2:0] state_t;

   localparam state_t StIdle    = 3'd0;
   localparam state_t StCapture = 3'd1;
   localparam state_t StCount   = 3'd2;
   localparam state_t StDone    = 3'd3;
   localparam state_t StTimeout = 3'd4;
   localparam state_t StZero    = 3'd5;

endpackage

// File: rtl/lfsr_period_mon.sv
// Measures the recurrence period of an LFSR output stream. The first valid
// sample after start becomes the reference. Each following valid sample is
// counted until the reference value appears again. An all-zero sample or
// an exhausted sample budget ends the search early.
module lfsr_period_mon
   import lfsr_pkg::*;
#(
   parameter int unsigned WIDTH   = LfsrWidth,
   parameter int unsigned MAX_CNT = 2 ** WIDTH
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic             valid_i,
   input  logic [WIDTH-1:0] data_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             timeout_o,
   output logic             zero_err_o,
   output logic [WIDTH:0]   period_o,
   output logic [WIDTH-1:0] ref_o
);

   localparam logic [WIDTH:0] MaxCnt = (WIDTH + 1)'(MAX_CNT);
   localparam logic [WIDTH:0] CntOne = (WIDTH + 1)'(1);

   state_t           state_q, state_d;
   logic [WIDTH:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0] ref_q, ref_d;
   logic [WIDTH:0]   period_q, period_d;

   logic [WIDTH:0]   cnt_inc;
   logic             sample_zero;
   logic             sample_match;

   // Saturating sample count and per-sample decisions
   always_comb begin
      cnt_inc      = (cnt_q == MaxCnt) ? cnt_q : cnt_q + CntOne;
      sample_zero  = (data_i == '0);
      sample_match = (data_i == ref_q);
   end

   // Next-state logic; zero beats match, match beats timeout
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      ref_d    = ref_q;
      period_d = period_q;
      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               state_d = StCapture;
            end
         end
         StCapture: begin
            if (!start_i) begin
               state_d = StIdle;
            end else if (valid_i) begin
               if (sample_zero) begin
                  state_d = StZero;
               end else begin
                  ref_d   = data_i;
                  cnt_d   = '0;
                  state_d = StCount;
               end
            end
         end
         StCount: begin
            if (!start_i) begin
               state_d = StIdle;
            end else if (valid_i) begin
               cnt_d = cnt_inc;
               if (sample_zero) begin
                  state_d = StZero;
               end else if (sample_match) begin
                  period_d = cnt_inc;
                  state_d  = StDone;
               end else if (cnt_inc >= MaxCnt) begin
                  period_d = '0;
                  state_d  = StTimeout;
               end
            end
         end
         StDone, StTimeout, StZero: begin
            // Result held until the requester drops start
            if (!start_i) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State, count, reference and result registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         ref_q    <= '0;
         period_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         ref_q    <= ref_d;
         period_q <= period_d;
      end
   end

   // Outputs decoded directly from the registered state
   always_comb begin
      busy_o     = (state_q == StCapture) || (state_q == StCount);
      done_o     = (state_q == StDone);
      timeout_o  = (state_q == StTimeout);
      zero_err_o = (state_q == StZero);
      period_o   = period_q;
      ref_o      = ref_q;
   end

endmodule

// File: doc/lfsr_period_mon.md
LFSR_PERIOD_MON -- requirements
Module: lfsr_period_mon

Interface
REQ-001 Parameter WIDTH, default 8: data width of the monitored LFSR stream.
REQ-002 Parameter MAX_CNT, default 2**WIDTH: sample count at which the search is abandoned.
REQ-003 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_ni  in  1  reset, asynchronous, active-low.
REQ-005 start_i  in  1  run enable; level-sensitive; high = measure, low = abort/clear.
REQ-006 valid_i  in  1  data_i qualifier; a sample is taken only on cycles with valid_i=1.
REQ-007 data_i  in  WIDTH  LFSR result from the upstream lfsr stage.
REQ-008 busy_o  out  1  measurement in progress.
REQ-009 done_o  out  1  period found; level, held until start_i falls.
REQ-010 timeout_o  out  1  no recurrence within MAX_CNT samples; level, held until start_i falls.
REQ-011 zero_err_o  out  1  all-zero sample seen (LFSR lock-up state); level, held until start_i falls.
REQ-012 period_o  out  WIDTH+1  measured period; valid while done_o=1.
REQ-013 ref_o  out  WIDTH  captured reference sample.

Function
REQ-014 States: IDLE, CAPTURE, COUNT, DONE, TIMEOUT, ZERO.
REQ-015 IDLE -> CAPTURE when start_i=1; busy_o=1 from the following cycle.
REQ-016 CAPTURE: first sample stored in ref_o; count cleared to 0; -> COUNT; a zero sample -> ZERO instead.
REQ-017 COUNT: each sample increments count by 1 (saturating at MAX_CNT, width WIDTH+1); cycles without valid_i leave count unchanged.
REQ-018 COUNT: sample equal to ref_o -> DONE; period_o = incremented count (first sample after capture that matches gives period 1).
REQ-019 COUNT: zero sample -> ZERO; zero check has priority over the match check and over the timeout check.
REQ-020 COUNT: incremented count reaching MAX_CNT without a match -> TIMEOUT; period_o = 0.
REQ-021 done_o, timeout_o, zero_err_o asserted in the cycle after the deciding sample; mutually exclusive; busy_o deasserted in that same cycle.
REQ-022 DONE/TIMEOUT/ZERO ignore valid_i and data_i; exit to IDLE only when start_i=0.
REQ-023 start_i=0 in CAPTURE or COUNT: abort -> IDLE next cycle; no flag set; period_o unchanged.
REQ-024 IDLE with start_i=0: all flags 0; period_o and ref_o retain last values.
REQ-025 Latency from start_i rising to first possible done_o: 3 cycles with continuous valid_i.

Reset
REQ-026 rst_ni=0 forces IDLE immediately, independent of clk_i.
REQ-027 Reset values: busy_o=0, done_o=0, timeout_o=0, zero_err_o=0, period_o=0, ref_o=0, internal count=0.
REQ-028 Reset asserted mid-measurement discards the measurement; after release the block waits in IDLE for start_i=1.

Structure
REQ-029 Shared package lfsr_pkg holds the state enumeration and the default WIDTH constant, shared with the lfsr stages.
REQ-030 Single module; no sub-module; one state register, one count register, one reference register.

Verification
REQ-031 Maximal 8-bit LFSR stream, seed 8'hAA, valid_i constant 1, start_i=1 -> done_o=1, period_o=255, ref_o=8'hAA.
REQ-032 Constant stream 8'h55 -> done_o=1, period_o=1, three cycles after start_i rising.
REQ-033 Stream 01,02,03,02,03,... with valid_i toggling every cycle -> timeout_o=1 after 256 counted samples, period_o=0.
REQ-034 Stream 8'h11, 8'h22, 8'h00 -> zero_err_o=1 one cycle after the 8'h00 sample; done_o=0.
REQ-035 rst_ni low for 1 cycle at the 100th sample of REQ-031 -> all outputs 0 immediately; restart then gives period_o=255.
REQ-036 start_i=0 at the 50th sample -> IDLE, no flags set; done_o held then cleared when start_i falls after REQ-032.
